data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, sets word-address width; storage depth is 2^ADDR_W 16-bit words.
REQ-002 Parameter LATENCY, default 4, is the request-to-response cycle count; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 enable  input  1  memory request strobe from the decode/control path.
REQ-006 wr  input  1  request type: 1 = write, 0 = read; sampled only with enable.
REQ-007 addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] and bits above ADDR_W are ignored.
REQ-008 data_in  input  16  write data; sampled only with enable.
REQ-009 data_out  output  16  read data; valid only while data_valid = 1.
REQ-010 data_valid  output  1  one-cycle response pulse: read data ready, or write committed.
REQ-011 busy  output  1  high while a request is outstanding; no new request is accepted.

Function
REQ-012 FSM states are IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-013 In IDLE with enable = 1, the block accepts the request and latches wr, the word index and data_in; next state is WAIT, with the wait counter loaded to LATENCY-2.
REQ-014 In IDLE with enable = 0, the block stays in IDLE with no side effects.
REQ-015 In WAIT, the counter decrements each cycle; when the counter is 0, next state is RESP.
REQ-016 The RESP cycle occurs exactly LATENCY cycles after the acceptance cycle (acceptance = cycle 0); data_valid = 1 only in RESP.
REQ-017 Read: in RESP, data_out = the stored word at the latched index.
REQ-018 Write: the latched data_in is written to the latched index on the clock edge that ends RESP; a read of the same index issued after that edge returns the new value.
REQ-019 RESP always returns to IDLE, so the minimum issue interval is LATENCY+1 cycles.
REQ-020 enable, wr, addr and data_in are ignored while busy = 1; the block neither queues nor drops with error, and the initiator must hold or retry.
REQ-021 data_out holds its last response value outside RESP and never shows unrequested data.
REQ-022 Word indices wrap modulo 2^ADDR_W; there is no out-of-range error.
REQ-023 When enable is asserted in the same cycle as RESP, that request is ignored; it is accepted only if enable is still high in the following IDLE cycle.

Reset
REQ-024 With rst_n = 0 at a clock edge: state = IDLE, counter = 0, data_valid = 0, busy = 0, data_out = 16'h0000.
REQ-025 Reset during WAIT or RESP abandons the request; a pending write is not committed and no data_valid pulse follows.
REQ-026 The storage array is not cleared by reset; its contents persist across reset.

Structure
REQ-027 The shared package holds the state enumeration (IDLE/WAIT/RESP) and the default LATENCY and ADDR_W constants.
REQ-028 Storage is one sub-module, dmem_array: single-port, synchronous write, combinational read, 16-bit wide, 2^ADDR_W deep.
REQ-029 The FSM, the counter and the request latches live in data_mem_resp; there is no other hierarchy.

Verification
REQ-030 Write then read: write addr 16'h0010 with data 16'hBEEF (LATENCY = 4), then read 16'h0010 -> write data_valid at cycle 4; read data_valid at cycle 4 of the read with data_out = 16'hBEEF.
REQ-031 Busy rejection: after acceptance, pulse enable with a write of 16'h1234 to 16'h0020 at cycles 1-3 -> no extra data_valid; a later read of 16'h0020 returns the prior value.
REQ-032 Wrap and byte bit: write 16'hA5A5 to 16'h0801 (ADDR_W = 10), read 16'h0000 -> data_out = 16'hA5A5.
REQ-033 Reset mid-write: write 16'h5555 to 16'h0040 over old value 16'h1111, assert rst_n = 0 at cycle 2 -> no data_valid, data_out = 0; a read of 16'h0040 then returns 16'h1111.
REQ-034 Back-to-back: hold enable high continuously with reads -> exactly one data_valid every 5 cycles and busy low for exactly one cycle between requests.
REQ-035 Latency parameter: run with LATENCY = 2 and LATENCY = 15 -> data_valid arrives exactly 2 and 15 cycles after acceptance.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and defaults for the fixed-latency data memory responder.
// Holds the FSM state encoding, bus widths and the default latency/depth.
package data_mem_resp_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BUS_ADDR_W  = 16;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Captured request payload; the word index is held separately because
  // its width follows the ADDR_W parameter of each instance.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Counter preload so that RESP lands exactly `lat` cycles after acceptance.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned lat);
    return CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset
// so contents survive a reset of the surrounding control logic.
module dmem_array
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned WORD_W = DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency data memory front end: accepts one request at a time and
// answers with a single data_valid pulse exactly LATENCY cycles later.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [BUS_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(LATENCY);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  req_t              req;
  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] rdata_c;
  logic              we_c;

  // Byte-select bit and bits above the word index do not address storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  // Commit on the edge closing RESP, unless that edge is a reset edge.
  assign we_c = (state == RESP) && req.wr && rst_n;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (DATA_W)
  ) u_dmem_array (
    .clk   (clk),
    .we    (we_c),
    .addr  (req_idx),
    .wdata (req.wdata),
    .rdata (rdata_c)
  );

  // Control FSM with request latches; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req        <= '0;
      req_idx    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            req.wr    <= wr;
            req.wdata <= data_in;
            req_idx   <= addr[ADDR_W:1];
            cnt       <= WAIT_LOAD;
            state     <= WAIT;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            data_valid <= 1'b1;
            // Write responses leave the previous read data on data_out.
            if (!req.wr) begin
              data_out <= rdata_c;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: scoreboard of expected responses
// against a reference word model, plus latency checks at LATENCY 2/4/15.
module tb_data_mem_resp;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, wr;
  logic [15:0] addr, data_in, data_out;
  logic        data_valid, busy;

  logic        en_s, wr_s;
  logic [15:0] addr_s, din_s;
  logic [15:0] dout2, dout15;
  logic        dv2, dv15, busy2, busy15;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [int];

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .wr(wr_s), .addr(addr_s),
    .data_in(din_s), .data_out(dout2), .data_valid(dv2), .busy(busy2)
  );

  data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .wr(wr_s), .addr(addr_s),
    .data_in(din_s), .data_out(dout15), .data_valid(dv15), .busy(busy15)
  );

  function automatic int widx(input logic [15:0] a);
    return int'(a[ADDR_W:1]);
  endfunction

  // Accept one request on the main DUT, then check latency and response.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    int   cyc;
    exp_t e;
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    if (w) begin
      model[widx(a)] = d;
      sb.push_back('{rd: 1'b0, data: d});
    end else begin
      sb.push_back('{rd: 1'b1, data: model[widx(a)]});
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      enable = 1'b0;
    end while (!data_valid && cyc < 40);
    n_tests++;
    if (!data_valid || cyc != int'(LAT)) begin
      n_fail++;
      $display("FAIL req_latency addr=%h: got %0d cycles expected %0d", a, cyc, LAT);
    end
    e = sb.pop_front();
    if (e.rd) begin
      n_tests++;
      if (data_out !== e.data) begin
        n_fail++;
        $display("FAIL read_data addr=%h: got %h expected %h", a, data_out, e.data);
      end
    end
    @(negedge clk);
    n_tests++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_resp addr=%h: got dv=%b busy=%b expected dv=0 busy=0", a, data_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got dv=%b busy=%b expected 0 0", data_valid, busy);
    end
    n_tests++;
    if (data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 0000", data_out);
    end
    n_tests++;
    if (dv2 !== 1'b0 || busy15 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_param_duts: got dv2=%b busy15=%b expected 0 0", dv2, busy15);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    do_req(1'b1, 16'h0010, 16'hBEEF);
    do_req(1'b0, 16'h0010, 16'h0000);
  endtask

  task automatic test_wrap();
    do_req(1'b1, 16'h0801, 16'hA5A5);
    do_req(1'b0, 16'h0000, 16'h0000);
    do_req(1'b1, 16'h07FE, 16'h3C3C);
    do_req(1'b0, 16'h0FFF, 16'h0000);
  endtask

  task automatic test_busy_reject();
    int pulses;
    do_req(1'b1, 16'h0020, 16'h7777);
    pulses = 0;
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0010; data_in = 16'h0000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (data_valid) begin
        pulses++;
        n_tests++;
        if (c != 4 || data_out !== 16'hBEEF) begin
          n_fail++;
          $display("FAIL reject_resp: got cycle %0d data %h expected cycle 4 data beef", c, data_out);
        end
      end
      if (c == 2 || c == 5) begin
        n_tests++;
        if (busy !== (c == 2)) begin
          n_fail++;
          $display("FAIL reject_busy c=%0d: got %b expected %b", c, busy, (c == 2));
        end
      end
      enable = (c <= 3);
      wr = 1'b1; addr = 16'h0020; data_in = 16'h1234;
    end
    enable = 1'b0;
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reject_pulses: got %0d expected 1", pulses);
    end
    do_req(1'b0, 16'h0020, 16'h0000);
  endtask

  task automatic test_reset_mid_req();
    int pulses;
    do_req(1'b1, 16'h0040, 16'h1111);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'h5555;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_wait: got dv=%b busy=%b dout=%h expected 0 0 0000", data_valid, busy, data_out);
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_valid) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_wait_pulse: got %0d expected 0", pulses);
    end
    do_req(1'b0, 16'h0040, 16'h0000);

    // Reset landing on the RESP cycle must also suppress the commit.
    do_req(1'b1, 16'h0050, 16'h2222);
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = 16'h0050; data_in = 16'h3333;
    repeat (4) begin
      @(negedge clk);
      enable = 1'b0;
    end
    n_tests++;
    if (data_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_cycle_dv: got %b expected 1", data_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got dv=%b busy=%b expected 0 0", data_valid, busy);
    end
    do_req(1'b0, 16'h0050, 16'h0000);
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] a;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== ((c % 5) != 0) || data_valid !== ((c % 5) == 4)) begin
        n_fail++;
        $display("FAIL b2b_ctrl c=%0d: got busy=%b dv=%b expected busy=%b dv=%b",
                 c, busy, data_valid, ((c % 5) != 0), ((c % 5) == 4));
      end
      if (data_valid && sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (data_out !== e.data) begin
          n_fail++;
          $display("FAIL b2b_data c=%0d: got %h expected %h", c, data_out, e.data);
        end
      end
      if (c == 25) begin
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        wr = 1'b0;
        if ((c % 5) == 0) begin
          a = ((c / 5) % 2 == 1) ? 16'h0000 : 16'h0010;
          addr = a;
          sb.push_back('{rd: 1'b1, data: model[widx(a)]});
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing: got %0d unanswered expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_latency();
    int first2, first15, cnt2, cnt15;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      en_s = 1'b1; wr_s = (pass == 0); addr_s = 16'h0006; din_s = 16'hC3C3;
      first2 = -1; first15 = -1; cnt2 = 0; cnt15 = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        en_s = 1'b0;
        if (dv2) begin
          cnt2++;
          if (first2 < 0) first2 = c;
          if (pass == 1) begin
            n_tests++;
            if (dout2 !== 16'hC3C3) begin
              n_fail++;
              $display("FAIL lat2_data: got %h expected c3c3", dout2);
            end
          end
        end
        if (dv15) begin
          cnt15++;
          if (first15 < 0) first15 = c;
          if (pass == 1) begin
            n_tests++;
            if (dout15 !== 16'hC3C3) begin
              n_fail++;
              $display("FAIL lat15_data: got %h expected c3c3", dout15);
            end
          end
        end
        if (c == 16) begin
          n_tests++;
          if (busy15 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_busy_end: got busy2=%b busy15=%b expected 0 0", busy2, busy15);
          end
        end
      end
      n_tests++;
      if (first2 != 2 || cnt2 != 1) begin
        n_fail++;
        $display("FAIL lat2: got first=%0d pulses=%0d expected 2 1", first2, cnt2);
      end
      n_tests++;
      if (first15 != 15 || cnt15 != 1) begin
        n_fail++;
        $display("FAIL lat15: got first=%0d pulses=%0d expected 15 1", first15, cnt15);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    en_s = 1'b0; wr_s = 1'b0; addr_s = '0; din_s = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_busy_reject();
    test_reset_mid_req();
    test_back_to_back();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
